// File: rtl/rc4_pkg.sv
// Shared RC4 constants and the key-scheduling FSM state encoding.
package rc4_pkg;
  localparam int KEY_BYTES = 3;
  localparam int KEY_WIDTH = 24;
  localparam int MEM_DEPTH = 256;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    READ_I  = 4'd1,
    WAIT_I  = 4'd2,
    LATCH_I = 4'd3,
    READ_J  = 4'd4,
    WAIT_J  = 4'd5,
    LATCH_J = 4'd6,
    WRITE_I = 4'd7,
    WRITE_J = 4'd8,
    INC     = 4'd9,
    DONE    = 4'd10
  } state_t;
endpackage

// File: rtl/ksa_key_sel.sv
// Picks key[idx] out of the packed secret key; key[0] is the top byte.
module ksa_key_sel
  import rc4_pkg::*;
(
  input  logic [KEY_WIDTH-1:0] i_secret_key,
  input  logic [1:0]           i_kidx,
  output logic [7:0]           o_key
);
  // Plain 3:1 mux; the unused index value falls back to key[0].
  always_comb begin
    o_key = i_secret_key[23:16];
    case (i_kidx)
      2'd1:    o_key = i_secret_key[15:8];
      2'd2:    o_key = i_secret_key[7:0];
      default: o_key = i_secret_key[23:16];
    endcase
  end
endmodule

// File: rtl/ksa_swap.sv
// RC4 key-scheduling pass over a 256-entry S memory with 1-cycle read latency.
// Memory-side outputs are decoded from state and registers only; q feeds
// nothing but the si/sj/j registers.
module ksa_swap
  import rc4_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [KEY_WIDTH-1:0] secret_key,
  input  logic [7:0]           q,
  output logic [7:0]           address,
  output logic [7:0]           data,
  output logic                 wen,
  output logic                 finito
);
  state_t     r_state, w_next;
  logic [7:0] r_i, r_j, r_si, r_sj;
  logic [1:0] r_kidx;
  logic       r_finito;
  logic [7:0] w_key;

  ksa_key_sel u_key_sel (
    .i_secret_key (secret_key),
    .i_kidx       (r_kidx),
    .o_key        (w_key)
  );

  // Next-state decode; start only matters in IDLE and DONE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = READ_I;
      READ_I:  w_next = WAIT_I;
      WAIT_I:  w_next = LATCH_I;
      LATCH_I: w_next = READ_J;
      READ_J:  w_next = WAIT_J;
      WAIT_J:  w_next = LATCH_J;
      LATCH_J: w_next = WRITE_I;
      WRITE_I: w_next = WRITE_J;
      WRITE_J: w_next = INC;
      INC:     w_next = (r_i == 8'hFF) ? DONE : READ_I;
      DONE:    if (start) w_next = READ_I;
      default: w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Datapath: indices, latched S values, key index counter and finito.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_i      <= 8'd0;
      r_j      <= 8'd0;
      r_si     <= 8'd0;
      r_sj     <= 8'd0;
      r_kidx   <= 2'd0;
      r_finito <= 1'b0;
    end else begin
      // finito lags DONE by one edge and drops on the restarting edge.
      r_finito <= (r_state == DONE) && !start;
      case (r_state)
        IDLE, DONE: if (start) begin
          r_i    <= 8'd0;
          r_j    <= 8'd0;
          r_kidx <= 2'd0;
        end
        LATCH_I: begin
          r_si <= q;
          r_j  <= r_j + q + w_key;
        end
        LATCH_J: r_sj <= q;
        INC: if (r_i != 8'hFF) begin
          r_i    <= r_i + 8'd1;
          r_kidx <= (r_kidx == 2'd2) ? 2'd0 : r_kidx + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Memory port decode; i==j needs no special case since both writes agree.
  always_comb begin
    address = 8'd0;
    data    = 8'd0;
    wen     = 1'b0;
    case (r_state)
      READ_I, WAIT_I, LATCH_I: address = r_i;
      READ_J, WAIT_J, LATCH_J: address = r_j;
      WRITE_I: begin
        address = r_i;
        data    = r_sj;
        wen     = 1'b1;
      end
      WRITE_J: begin
        address = r_j;
        data    = r_si;
        wen     = 1'b1;
      end
      default: ;
    endcase
  end

  assign finito = r_finito;
endmodule

// File: tb/tb_ksa_swap.sv
// Directed bench for ksa_swap with a registered-address 256x8 RAM model.
`timescale 1ns/1ps
module tb_ksa_swap;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [23:0] secret_key = 24'd0;
  logic [7:0]  q, address, data;
  logic        wen, finito;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  mem [0:255];
  logic [7:0]  r_addr = 8'd0;
  logic        preload = 1'b0;
  logic [7:0]  exp_mem [0:255];

  logic [15:0] wlog [0:4095];
  int          wcnt = 0;

  always #5 clk = ~clk;

  ksa_swap dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .secret_key (secret_key),
    .q          (q),
    .address    (address),
    .data       (data),
    .wen        (wen),
    .finito     (finito)
  );

  // RAM: address registered, read data combinational from the registered address.
  always @(posedge clk) begin
    if (preload) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
    end else if (wen) begin
      mem[address] <= data;
    end
    r_addr <= address;
  end
  assign q = mem[r_addr];

  // Write logger, sampled mid-cycle.
  always @(negedge clk) begin
    if (wen) begin
      if (wcnt < 4096) wlog[wcnt] <= {address, data};
      wcnt <= wcnt + 1;
    end
  end

  task automatic do_preload();
    @(negedge clk);
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
  endtask

  task automatic build_ref(input logic [23:0] key);
    logic [7:0] kb [0:2];
    logic [7:0] j, t;
    kb[0] = key[23:16]; kb[1] = key[15:8]; kb[2] = key[7:0];
    for (int k = 0; k < 256; k++) exp_mem[k] = 8'(k);
    j = 8'd0;
    for (int k = 0; k < 256; k++) begin
      j = j + exp_mem[k] + kb[k % 3];
      t = exp_mem[k]; exp_mem[k] = exp_mem[j]; exp_mem[j] = t;
    end
  endtask

  // Runs one pass; edges counts rising edges after the one that sampled start.
  task automatic run_pass(input logic [23:0] key, input bit toggle,
                          output int edges, output int nwen, output int base,
                          output logic fin0);
    int cnt;
    @(negedge clk);
    secret_key = key;
    start = 1'b1;
    base = wcnt;
    @(posedge clk);
    #1 start = 1'b0;
    fin0 = finito;
    cnt = 0;
    while (cnt < 3000) begin
      @(posedge clk);
      #1 cnt++;
      if (toggle && cnt < 2000) start = (cnt % 5 == 0) || (cnt % 7 == 0);
      else start = 1'b0;
      if (finito) break;
    end
    edges = cnt;
    @(negedge clk);
    nwen = wcnt - base;
  endtask

  task automatic check_ram(input logic [23:0] key, input string tag);
    int diff;
    bit seen [0:255];
    int dup;
    build_ref(key);
    diff = 0; dup = 0;
    for (int k = 0; k < 256; k++) seen[k] = 1'b0;
    for (int k = 0; k < 256; k++) begin
      if (mem[k] !== exp_mem[k]) diff++;
      if (seen[mem[k]]) dup++;
      seen[mem[k]] = 1'b1;
    end
    n_cmp++;
    if (diff !== 0) begin
      n_err++;
      $display("FAIL %s ram_ref: %0d entries differ, required 0", tag, diff);
    end
    n_cmp++;
    if (dup !== 0) begin
      n_err++;
      $display("FAIL %s ram_perm: %0d duplicate values, required 0", tag, dup);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({wen, finito, address, data} !== 18'd0) begin
      n_err++;
      $display("FAIL reset_outputs: wen=%b finito=%b addr=%h data=%h, required all 0",
               wen, finito, address, data);
    end
    @(negedge clk) reset = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (wen !== 1'b0 || address !== 8'd0 || finito !== 1'b0 || wcnt !== 0) begin
      n_err++;
      $display("FAIL idle_wait: wen=%b addr=%h finito=%b writes=%0d, required 0/0/0/0",
               wen, address, finito, wcnt);
    end
  endtask

  task automatic test_key_010203();
    int e, nw, b;
    logic f0;
    logic [15:0] exp_w [0:3];
    exp_w[0] = 16'h0001; exp_w[1] = 16'h0100; exp_w[2] = 16'h0103; exp_w[3] = 16'h0300;
    do_preload();
    run_pass(24'h010203, 1'b0, e, nw, b, f0);
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (wlog[b+k] !== exp_w[k]) begin
        n_err++;
        $display("FAIL k010203_write%0d: addr/data=%h, required %h", k, wlog[b+k], exp_w[k]);
      end
    end
    n_cmp++;
    if (e !== 2305) begin
      n_err++;
      $display("FAIL k010203_latency: %0d edges, required 2305", e);
    end
    n_cmp++;
    if (nw !== 512) begin
      n_err++;
      $display("FAIL k010203_wen_count: %0d, required 512", nw);
    end
    check_ram(24'h010203, "k010203");
  endtask

  task automatic test_key_zero();
    int e, nw, b;
    logic f0;
    logic [15:0] exp_w [0:5];
    exp_w[0] = 16'h0000; exp_w[1] = 16'h0000; exp_w[2] = 16'h0101;
    exp_w[3] = 16'h0101; exp_w[4] = 16'h0203; exp_w[5] = 16'h0302;
    do_preload();
    run_pass(24'h000000, 1'b0, e, nw, b, f0);
    for (int k = 0; k < 6; k++) begin
      n_cmp++;
      if (wlog[b+k] !== exp_w[k]) begin
        n_err++;
        $display("FAIL kzero_write%0d: addr/data=%h, required %h", k, wlog[b+k], exp_w[k]);
      end
    end
    n_cmp++;
    if (e !== 2305 || nw !== 512) begin
      n_err++;
      $display("FAIL kzero_timing: edges=%0d wen=%0d, required 2305/512", e, nw);
    end
    check_ram(24'h000000, "kzero");
  endtask

  task automatic test_mid_reset();
    int guard, w0;
    do_preload();
    @(negedge clk);
    secret_key = 24'hA5C3F0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!wen && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    n_cmp++;
    if (!wen) begin
      n_err++;
      $display("FAIL midreset_reach_write: wen=%b after %0d cycles, required 1", wen, guard);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (wen !== 1'b0 || finito !== 1'b0 || address !== 8'd0) begin
      n_err++;
      $display("FAIL midreset_async: wen=%b finito=%b addr=%h, required 0/0/00",
               wen, finito, address);
    end
    @(negedge clk) reset = 1'b0;
    w0 = wcnt;
    repeat (20) @(negedge clk);
    n_cmp++;
    if (wcnt !== w0 || address !== 8'd0 || finito !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_idle: writes=%0d addr=%h finito=%b, required 0/00/0",
               wcnt - w0, address, finito);
    end
  endtask

  task automatic test_back_to_back();
    int e, nw, b;
    logic f0;
    do_preload();
    run_pass(24'h5A17C4, 1'b0, e, nw, b, f0);
    n_cmp++;
    if (e !== 2305 || finito !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_first: edges=%0d finito=%b, required 2305/1", e, finito);
    end
    check_ram(24'h5A17C4, "b2b_first");
    repeat (3) @(negedge clk);
    do_preload();
    n_cmp++;
    if (finito !== 1'b1) begin
      n_err++;
      $display("FAIL done_hold: finito=%b, required 1", finito);
    end
    run_pass(24'hFFFFFF, 1'b1, e, nw, b, f0);
    n_cmp++;
    if (f0 !== 1'b0) begin
      n_err++;
      $display("FAIL restart_finito_drop: finito=%b, required 0", f0);
    end
    n_cmp++;
    if (e !== 2305 || nw !== 512) begin
      n_err++;
      $display("FAIL restart_toggle_timing: edges=%0d wen=%0d, required 2305/512", e, nw);
    end
    check_ram(24'hFFFFFF, "restart");
  endtask

  initial begin
    test_reset();
    test_key_010203();
    test_key_zero();
    test_mid_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
